// File: rtl/word_bit_transmitter.sv
// rtl/word_bit_transmitter.sv - serialises a parallel word onto a 1-bit line with start, parity and stop bits
module word_bit_transmitter #(
    parameter int WORD_WIDTH   = 32,
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_EN    = 1,
    parameter int STOP_BITS    = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WORD_WIDTH-1:0] in_data,
    output logic                  out_bit,
    output logic                  busy,
    output logic                  done
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(WORD_WIDTH - 1);
    localparam logic             STOP_LAST = (STOP_BITS > 1);

    typedef enum logic [7:0] {
        IDLE   = 8'd0,
        START  = 8'd1,
        DATA   = 8'd2,
        PARITY = 8'd3,
        STOP   = 8'd4
    } state_e;

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        bit_idx_q, bit_idx_d;
    logic [WORD_WIDTH-1:0]   shift_q, shift_d;
    logic                    par_q, par_d;
    logic                    stop_idx_q, stop_idx_d;
    logic                    out_bit_q, out_bit_d;
    logic                    done_q, done_d;
    logic                    in_ready_q, in_ready_d;
    logic                    busy_q, busy_d;

    logic                    bit_end;
    logic                    accept;

    assign bit_end = (cnt_q == CNT_LAST);
    assign accept  = (state_q == IDLE) && in_valid && in_ready_q;

    // Next-state and next-output decode; outputs are derived from the next
    // state so the registered line changes on the same edge as the state.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        par_d      = par_q;
        stop_idx_d = stop_idx_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    shift_d    = in_data;
                    par_d      = ^in_data;
                    state_d    = START;
                    cnt_d      = '0;
                    bit_idx_d  = '0;
                    stop_idx_d = 1'b0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    shift_d = shift_q >> 1;
                    if (bit_idx_q == IDX_LAST) begin
                        bit_idx_d = '0;
                        state_d   = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + IDX_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            STOP: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (stop_idx_q == STOP_LAST) begin
                        state_d    = IDLE;
                        stop_idx_d = 1'b0;
                    end else begin
                        stop_idx_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        case (state_d)
            START:   out_bit_d = 1'b0;
            DATA:    out_bit_d = shift_d[0];
            PARITY:  out_bit_d = par_d;
            default: out_bit_d = 1'b1;
        endcase

        done_d     = (state_d == STOP) && (cnt_d == CNT_LAST) && (stop_idx_d == STOP_LAST);
        in_ready_d = (state_d == IDLE);
        busy_d     = (state_d != IDLE);
    end

    // State and output registers; async reset drops the line back to idle at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            stop_idx_q <= 1'b0;
            out_bit_q  <= 1'b1;
            done_q     <= 1'b0;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            stop_idx_q <= stop_idx_d;
            out_bit_q  <= out_bit_d;
            done_q     <= done_d;
            in_ready_q <= in_ready_d;
            busy_q     <= busy_d;
        end
    end

    assign out_bit  = out_bit_q;
    assign done     = done_q;
    assign in_ready = in_ready_q;
    assign busy     = busy_q;

endmodule
